// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning the HI/LO register pair.
// Multiplies take MUL_LATENCY cycles; divides use a restoring, one-bit-per-cycle datapath.
module muldiv_sequencer #(
    parameter int MUL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        Mul,
    input  logic        Unsigned,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic        ReadHi,
    input  logic        ReadLo,
    input  logic        WriteHi,
    input  logic        WriteLo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt;
    logic [31:0] a_q, b_q;
    logic        uns_q;
    logic [31:0] quo_q, rem_q, dvs_q;

    logic [63:0] mul_a, mul_b, product;
    logic [31:0] abs_a, abs_b;
    logic [32:0] shifted;
    logic [33:0] diff;
    logic        neg_q, neg_r;

    // Sign-extending to 64 bits lets one unsigned multiplier serve both signed and unsigned products.
    assign mul_a   = {{32{a_q[31] & ~uns_q}}, a_q};
    assign mul_b   = {{32{b_q[31] & ~uns_q}}, b_q};
    assign product = mul_a * mul_b;

    assign abs_a   = (!uns_q && a_q[31]) ? -a_q : a_q;
    assign abs_b   = (!uns_q && b_q[31]) ? -b_q : b_q;
    assign shifted = {rem_q, quo_q[31]};
    assign diff    = {1'b0, shifted} - {2'b00, dvs_q};
    assign neg_q   = ~uns_q & (a_q[31] ^ b_q[31]);
    assign neg_r   = ~uns_q & a_q[31];

    assign busy  = (state != IDLE);
    assign stall = busy & (start | ReadHi | ReadLo | WriteHi | WriteLo);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = Mul ? MUL : DIV;
            MUL:  if (cnt == 6'd0) state_nxt = IDLE;
            DIV:  if (cnt == 6'd0) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // DIV spends its first cycle loading magnitudes (cnt=32), then iterates on cnt=31..0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            uns_q <= 1'b0;
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= op1;
                        b_q   <= op2;
                        uns_q <= Unsigned;
                        cnt   <= Mul ? 6'(MUL_LATENCY - 1) : 6'd32;
                    end else begin
                        if (WriteHi) hi <= op1;
                        if (WriteLo) lo <= op1;
                    end
                end
                MUL: begin
                    if (cnt == 6'd0) begin
                        {hi, lo} <= product;
                        done     <= 1'b1;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                DIV: begin
                    if (cnt == 6'd32) begin
                        quo_q <= abs_a;
                        rem_q <= '0;
                        dvs_q <= abs_b;
                    end else if (!diff[33]) begin
                        rem_q <= diff[31:0];
                        quo_q <= {quo_q[30:0], 1'b1};
                    end else begin
                        rem_q <= shifted[31:0];
                        quo_q <= {quo_q[30:0], 1'b0};
                    end
                    if (cnt != 6'd0) cnt <= cnt - 6'd1;
                end
                FIX: begin
                    // A zero divisor still completes, but leaves HI/LO untouched.
                    if (dvs_q != 32'd0) begin
                        lo <= neg_q ? -quo_q : quo_q;
                        hi <= neg_r ? -rem_q : rem_q;
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench for muldiv_sequencer: a cycle-count/arithmetic model predicts busy, done,
// stall, hi and lo every cycle, and directed cases pin known results and latencies.
module tb_muldiv_sequencer;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start, Mul, Unsigned, ReadHi, ReadLo, WriteHi, WriteLo;
    logic [31:0] op1, op2;
    logic [31:0] hi, lo;
    logic        busy, done, stall;

    muldiv_sequencer #(.MUL_LATENCY(L)) dut (
        .clk(clk), .reset(reset), .start(start), .Mul(Mul), .Unsigned(Unsigned),
        .op1(op1), .op2(op2), .ReadHi(ReadHi), .ReadLo(ReadLo),
        .WriteHi(WriteHi), .WriteLo(WriteLo),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model: remaining busy cycles plus the result to commit when they run out.
    logic [31:0] m_hi, m_lo;
    int          m_rem;
    bit          m_done;
    logic [63:0] p_res;
    bit          p_skip;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [64:0] ref_op(input logic mul, input logic uns,
                                           input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sq, sr;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        if (mul) begin
            if (uns) p = {32'b0, a} * {32'b0, b};
            else     p = sa * sb;
            return {1'b0, p};
        end
        if (b == 32'd0) return {1'b1, 64'd0};
        if (uns) return {1'b0, a % b, a / b};
        sq = sa / sb;
        sr = sa % sb;
        return {1'b0, sr[31:0], sq[31:0]};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi = '0; m_lo = '0; m_rem = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    if (!p_skip) {m_hi, m_lo} = p_res;
                    m_done = 1'b1;
                end
            end else if (start) begin
                {p_skip, p_res} = ref_op(Mul, Unsigned, op1, op2);
                m_rem = Mul ? L : 34;
            end else begin
                if (WriteHi) m_hi = op1;
                if (WriteLo) m_lo = op1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",  64'(busy),  64'(m_rem > 0));
            check("done",  64'(done),  64'(m_done));
            check("hi",    64'(hi),    64'(m_hi));
            check("lo",    64'(lo),    64'(m_lo));
            check("stall", 64'(stall),
                  64'((m_rem > 0) && (start || ReadHi || ReadLo || WriteHi || WriteLo)));
        end
    end

    task automatic quiet();
        start = 1'b0; Mul = 1'b0; Unsigned = 1'b0;
        ReadHi = 1'b0; ReadLo = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: quiet while busy; 1: random pipeline noise; 2: hold start+ReadLo and expect stall
    task automatic run_op(input logic mul, input logic uns, input logic [31:0] a,
                          input logic [31:0] b, input int mode,
                          output int done_at, output int busy_cnt);
        start = 1'b1; Mul = mul; Unsigned = uns; op1 = a; op2 = b;
        tick();
        quiet();
        done_at = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 60; k++) begin
            if (m_rem > 0 && mode == 1) begin
                start = 1'($urandom); Mul = 1'($urandom); Unsigned = 1'($urandom);
                ReadHi = 1'($urandom); ReadLo = 1'($urandom);
                WriteHi = 1'($urandom); WriteLo = 1'($urandom);
                op1 = $urandom; op2 = $urandom;
            end else if (m_rem > 0 && mode == 2) begin
                start = 1'b1; ReadLo = 1'b1; op1 = $urandom; op2 = $urandom;
            end else begin
                quiet();
            end
            @(negedge clk);
            if (mode == 2 && m_rem > 0) check("stall_hold", 64'(stall), 64'd1);
            if (busy) busy_cnt++;
            if (done) begin
                done_at = k;
                break;
            end
            tick();
        end
        check("done_seen", 64'(done_at != 0), 64'd1);
        tick();
        quiet();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    int da, bc, dcnt;

    initial begin
        quiet();
        op1 = '0; op2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_hi",   64'(hi),   64'd0);
        check("rst_lo",   64'(lo),   64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);

        // release, then start in the same cycle: accepted on the first edge
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_op(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd7, 0, da, bc);
        check("smul_done_at", 64'(da), 64'd3);
        check("smul_busy",    64'(bc), 64'd2);
        check("smul_hi",      64'(hi), 64'hFFFF_FFFF);
        check("smul_lo",      64'(lo), 64'hFFFF_FFEB);

        run_op(1'b0, 1'b1, 32'd100, 32'd7, 0, da, bc);
        check("udiv_done_at", 64'(da), 64'd35);
        check("udiv_busy",    64'(bc), 64'd34);
        check("udiv_lo",      64'(lo), 64'd14);
        check("udiv_hi",      64'(hi), 64'd2);

        run_op(1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, 2, da, bc);
        check("sdiv_done_at", 64'(da), 64'd35);
        check("sdiv_lo",      64'(lo), 64'hFFFF_FFFD);
        check("sdiv_hi",      64'(hi), 64'hFFFF_FFFF);
        ReadLo = 1'b1;
        @(negedge clk);
        check("stall_after_done", 64'(stall), 64'd0);
        tick();
        quiet();

        run_op(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, da, bc);
        check("ovf_lo", 64'(lo), 64'h8000_0000);
        check("ovf_hi", 64'(hi), 64'd0);

        WriteHi = 1'b1; op1 = 32'h1234;
        tick();
        quiet();
        WriteLo = 1'b1; op1 = 32'h5678;
        tick();
        quiet();
        @(negedge clk);
        check("wr_hi", 64'(hi), 64'h1234);
        check("wr_lo", 64'(lo), 64'h5678);
        tick();
        run_op(1'b0, 1'b1, 32'd9, 32'd0, 1, da, bc);
        check("dz_done_at", 64'(da), 64'd35);
        check("dz_hi",      64'(hi), 64'h1234);
        check("dz_lo",      64'(lo), 64'h5678);

        // start beats simultaneous writes
        WriteHi = 1'b1; WriteLo = 1'b1;
        run_op(1'b1, 1'b1, 32'd3, 32'd5, 0, da, bc);
        check("sw_hi", 64'(hi), 64'd0);
        check("sw_lo", 64'(lo), 64'd15);

        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                WriteHi = 1'($urandom); WriteLo = 1'($urandom);
                ReadHi = 1'($urandom); ReadLo = 1'($urandom);
                op1 = $urandom;
                tick();
                quiet();
            end
            run_op(1'($urandom), 1'($urandom), pick(), pick(), 1, da, bc);
        end

        // abort a divide mid-iteration
        WriteHi = 1'b1; WriteLo = 1'b1; op1 = 32'hAAAA_5555;
        tick();
        quiet();
        start = 1'b1; Mul = 1'b0; Unsigned = 1'b1; op1 = 32'd1000; op2 = 32'd3;
        tick();
        quiet();
        repeat (10) tick();
        #3;
        reset = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi",   64'(hi),   64'd0);
        check("abort_lo",   64'(lo),   64'd0);
        check("abort_done", 64'(done), 64'd0);
        tick();
        reset = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("abort_no_done", 64'(dcnt), 64'd0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
